// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Works on operand magnitudes (shift-add multiply, restoring divide) and applies
// the sign on the edge that enters FIN, so result is a registered value.
// Handshake: start is sampled only while busy=0 (IDLE or FIN); funct3/srcA/srcB
// need only be valid in that start cycle; done pulses for one cycle with result
// valid in the same cycle; flush aborts any state and wins over a same-cycle start.
module muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int N  = XLEN / UNROLL;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   a_q, a_d;        // multiplicand or divisor magnitude
   logic [2*XLEN:0]   acc_q, acc_d;    // {hi, lo} product or {rem, dividend/quotient}
   logic [XLEN-1:0]   result_q, result_d;

   logic [2*XLEN:0]   step_acc;
   logic [XLEN:0]     shl;
   logic [XLEN:0]     sum;
   logic [XLEN+1:0]   trial;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   div_val;
   logic [XLEN-1:0]   fin_val;
   logic              sign_a, sign_b, ovf;
   logic [XLEN-1:0]   mag_a, mag_b;

   // Issue decode: operand signedness, magnitudes and the signed-overflow case
   always_comb begin
      sign_a = 1'b0;
      sign_b = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sign_a = srcA[XLEN-1];
            sign_b = srcB[XLEN-1];
         end
         3'b010:  sign_a = srcA[XLEN-1];
         default: ;
      endcase
      mag_a = sign_a ? -srcA : srcA;
      mag_b = sign_b ? -srcB : srcB;
      ovf   = (funct3 == 3'b100 || funct3 == 3'b110) && (srcA == MIN_NEG) && (srcB == '1);
   end

   // UNROLL iteration steps: shift-add (LSB first) or restoring subtract (MSB first)
   always_comb begin
      step_acc = acc_q;
      shl      = '0;
      sum      = '0;
      trial    = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            shl   = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
            trial = {1'b0, shl} - {2'b00, a_q};
            if (trial[XLEN+1]) begin
               step_acc = {shl, step_acc[XLEN-2:0], 1'b0};
            end else begin
               step_acc = {trial[XLEN:0], step_acc[XLEN-2:0], 1'b1};
            end
         end else begin
            sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, a_q} : '0);
            step_acc = {1'b0, sum, step_acc[XLEN-1:1]};
         end
      end
   end

   // Sign fix-up and half selection of the final iteration's value
   always_comb begin
      prod    = neg_q ? -step_acc[2*XLEN-1:0] : step_acc[2*XLEN-1:0];
      div_val = op_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
      if (neg_q) begin
         div_val = -div_val;
      end
      if (op_q[2]) begin
         fin_val = div_val;
      end else if (op_q[1:0] == 2'b00) begin
         fin_val = prod[XLEN-1:0];
      end else begin
         fin_val = prod[2*XLEN-1:XLEN];
      end
   end

   // Next-state and outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      a_d      = a_q;
      acc_d    = acc_q;
      result_d = result_q;
      busy     = (state_q == CALC);
      done     = (state_q == FIN) && !flush;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, FIN: begin
               if (start) begin
                  op_d  = funct3;
                  neg_d = (funct3 == 3'b110) ? sign_a : (sign_a ^ sign_b);
                  if (funct3[2] && srcB == '0) begin
                     result_d = funct3[1] ? srcA : '1;
                     state_d  = FIN;
                  end else if (ovf) begin
                     result_d = funct3[1] ? '0 : srcA;
                     state_d  = FIN;
                  end else begin
                     a_d     = funct3[2] ? mag_b : mag_a;
                     acc_d   = {{(XLEN+1){1'b0}}, (funct3[2] ? mag_a : mag_b)};
                     cnt_d   = CW'(N);
                     state_d = CALC;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            CALC: begin
               acc_d = step_acc;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  result_d = fin_val;
                  state_d  = FIN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         a_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule
